// File: rtl/branch_direction_predictor.sv
// Bimodal 2-bit branch direction predictor with F->D->E prediction tracking.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history register into the index.
module branch_direction_predictor #(
   parameter int IDX_W = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pcF,
   input  logic        btbHit,
   input  logic [31:0] btbBTA,
   input  logic        stallF,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        flushE,
   input  logic        branchE,
   input  logic        branchTakenE,
   input  logic [31:0] aluBranchAddress,
   input  logic [31:0] pcE,
   output logic [31:0] pcNextF,
   output logic        predictTakenF,
   output logic        branchPredictedE,
   output logic        mispredictE,
   output logic [31:0] pcRedirectE
);

   localparam int N = 1 << IDX_W;

   logic [1:0]       ctr [N];
   logic [IDX_W-1:0] idx_f;

   logic             fd_valid;
   logic             fd_taken;
   logic [31:0]      fd_target;
   logic [IDX_W-1:0] fd_idx;

   logic             de_valid;
   logic             de_taken;
   logic [31:0]      de_target;
   logic [IDX_W-1:0] de_idx;

   logic             resolve;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [IDX_W-1:0] ghr;

   always_ff @(posedge clk) begin
      if (reset)
         ghr <= '0;
      else if (resolve)
         ghr <= {ghr[IDX_W-2:0], branchTakenE};
   end

   assign idx_f = pcF[IDX_W+1:2] ^ ghr;
`else
   assign idx_f = pcF[IDX_W+1:2];
`endif

   assign predictTakenF = btbHit & ctr[idx_f][1];
   assign pcNextF       = predictTakenF ? btbBTA : pcF + 32'd4;

   assign resolve          = branchE & de_valid;
   assign branchPredictedE = de_valid & de_taken;
   assign mispredictE      = resolve &
                             ((de_taken != branchTakenE) |
                              (de_taken & branchTakenE &
                               (de_target != aluBranchAddress)));
   assign pcRedirectE      = branchTakenE ? aluBranchAddress : pcE + 32'd4;

   // Flush only kills valid/taken; target and index follow the stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         fd_valid  <= 1'b0;
         fd_taken  <= 1'b0;
         fd_target <= '0;
         fd_idx    <= '0;
      end else begin
         if (!stallF) begin
            fd_target <= btbBTA;
            fd_idx    <= idx_f;
         end
         if (flushD) begin
            fd_valid <= 1'b0;
            fd_taken <= 1'b0;
         end else if (!stallF) begin
            fd_valid <= 1'b1;
            fd_taken <= predictTakenF;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         de_valid  <= 1'b0;
         de_taken  <= 1'b0;
         de_target <= '0;
         de_idx    <= '0;
      end else begin
         if (!stallD) begin
            de_target <= fd_target;
            de_idx    <= fd_idx;
         end
         if (flushE) begin
            de_valid <= 1'b0;
            de_taken <= 1'b0;
         end else if (!stallD) begin
            de_valid <= fd_valid;
            de_taken <= fd_taken;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++)
            ctr[i] <= 2'd1;
      end else if (resolve) begin
         if (branchTakenE && ctr[de_idx] != 2'd3)
            ctr[de_idx] <= ctr[de_idx] + 2'd1;
         else if (!branchTakenE && ctr[de_idx] != 2'd0)
            ctr[de_idx] <= ctr[de_idx] - 2'd1;
      end
   end

endmodule

// File: tb/tb_branch_direction_predictor.sv
// Directed and random checks of branch_direction_predictor against a
// behavioural model of counters and in-flight predictions.
module tb_branch_direction_predictor;

   localparam int IDX_W = 4;
   localparam int N     = 1 << IDX_W;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pcF;
   logic        btbHit;
   logic [31:0] btbBTA;
   logic        stallF;
   logic        stallD;
   logic        flushD;
   logic        flushE;
   logic        branchE;
   logic        branchTakenE;
   logic [31:0] aluBranchAddress;
   logic [31:0] pcE;
   logic [31:0] pcNextF;
   logic        predictTakenF;
   logic        branchPredictedE;
   logic        mispredictE;
   logic [31:0] pcRedirectE;

   int total = 0;
   int bad   = 0;

   branch_direction_predictor #(.IDX_W(IDX_W)) dut (
      .clk(clk),
      .reset(reset),
      .pcF(pcF),
      .btbHit(btbHit),
      .btbBTA(btbBTA),
      .stallF(stallF),
      .stallD(stallD),
      .flushD(flushD),
      .flushE(flushE),
      .branchE(branchE),
      .branchTakenE(branchTakenE),
      .aluBranchAddress(aluBranchAddress),
      .pcE(pcE),
      .pcNextF(pcNextF),
      .predictTakenF(predictTakenF),
      .branchPredictedE(branchPredictedE),
      .mispredictE(mispredictE),
      .pcRedirectE(pcRedirectE)
   );

   always #5 clk = ~clk;

   // Model: per-index counters and two in-flight prediction records.
   typedef struct {
      bit          valid;
      bit          taken;
      logic [31:0] target;
      int          idx;
   } rec_t;

   int   m_cnt [N];
   int   m_ghr;
   rec_t m_fd;
   rec_t m_de;

   bit          e_pt;
   logic [31:0] e_next;
   bit          e_bpe;
   bit          e_res;
   bit          e_mis;
   logic [31:0] e_red;

   function automatic int fetch_idx(logic [31:0] pc);
      int i;
      i = int'((pc >> 2) % N);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      i = i ^ m_ghr;
`endif
      return i;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_cnt[i] = 1;
      m_ghr = 0;
      m_fd  = '{0, 0, 32'h0, 0};
      m_de  = '{0, 0, 32'h0, 0};
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic eval();
      int fi;
      #1;
      fi     = fetch_idx(pcF);
      e_pt   = btbHit && m_cnt[fi] >= 2;
      e_next = e_pt ? btbBTA : pcF + 32'd4;
      e_bpe  = m_de.valid && m_de.taken;
      e_res  = branchE && m_de.valid;
      e_mis  = e_res && (m_de.taken != branchTakenE ||
               (m_de.taken && branchTakenE && m_de.target != aluBranchAddress));
      e_red  = branchTakenE ? aluBranchAddress : pcE + 32'd4;
      chk("predictTakenF", {31'b0, predictTakenF}, {31'b0, e_pt});
      chk("pcNextF", pcNextF, e_next);
      chk("branchPredictedE", {31'b0, branchPredictedE}, {31'b0, e_bpe});
      chk("mispredictE", {31'b0, mispredictE}, {31'b0, e_mis});
      if (e_mis) chk("pcRedirectE", pcRedirectE, e_red);
   endtask

   task automatic advance();
      rec_t nf;
      int   fi;
      if (reset) begin
         model_reset();
      end else begin
         fi = fetch_idx(pcF);
         nf = '{1, e_pt, btbBTA, fi};
         if (e_res) begin
            if (branchTakenE) m_cnt[m_de.idx] = (m_cnt[m_de.idx] == 3) ? 3 : m_cnt[m_de.idx] + 1;
            else              m_cnt[m_de.idx] = (m_cnt[m_de.idx] == 0) ? 0 : m_cnt[m_de.idx] - 1;
            m_ghr = ((m_ghr << 1) | int'(branchTakenE)) % N;
         end
         if (!stallD) begin
            m_de.target = m_fd.target;
            m_de.idx    = m_fd.idx;
            m_de.valid  = m_fd.valid;
            m_de.taken  = m_fd.taken;
         end
         if (flushE) begin
            m_de.valid = 0;
            m_de.taken = 0;
         end
         if (!stallF) m_fd = nf;
         if (flushD) begin
            m_fd.valid = 0;
            m_fd.taken = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      reset = 0; stallF = 0; stallD = 0; flushD = 0; flushE = 0;
      branchE = 0; branchTakenE = 0;
   endtask

   initial begin
      reset = 1; pcF = 0; btbHit = 0; btbBTA = 0;
      stallF = 0; stallD = 0; flushD = 0; flushE = 0;
      branchE = 0; branchTakenE = 0; aluBranchAddress = 0; pcE = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // reset state
      eval();
      chk("reset_bpe", {31'b0, branchPredictedE}, 32'h0);
      chk("reset_mis", {31'b0, mispredictE}, 32'h0);
      advance();

      // Test 1: c0, fresh counter is weakly not-taken
      quiet();
      pcF = 32'h08; btbHit = 1; btbBTA = 32'h11;
      aluBranchAddress = 32'h11; pcE = 32'h08;
      eval();
      chk("t1_pt", {31'b0, predictTakenF}, 32'h0);
      chk("t1_next", pcNextF, 32'h0C);
      advance();
      eval(); advance();                       // c1

      // Test 2: two taken resolves, c2 and c3
      branchE = 1; branchTakenE = 1;
      eval();
      chk("t2_mis_a", {31'b0, mispredictE}, 32'h1);
      chk("t2_red_a", pcRedirectE, 32'h11);
      advance();
      eval(); advance();
      branchE = 0;
      eval();                                  // c4: counter now 3
      chk("t2_pt", {31'b0, predictTakenF}, 32'h1);
      chk("t2_next", pcNextF, 32'h11);
      advance();

      // Test 3: c5, predicted taken resolves not-taken
      branchE = 1; branchTakenE = 0;
      eval();
      chk("t3_mis", {31'b0, mispredictE}, 32'h1);
      chk("t3_red", pcRedirectE, 32'h0C);
      advance();

      // Test 4: c6, taken to a different target
      branchTakenE = 1; aluBranchAddress = 32'h20;
      eval();
      chk("t4_mis", {31'b0, mispredictE}, 32'h1);
      chk("t4_red", pcRedirectE, 32'h20);
      advance();

      // Test 5: c7 flushE+stallD on valid taken prediction
      branchE = 0; aluBranchAddress = 32'h11;
      flushE = 1; stallD = 1;
      eval();
      chk("t5_bpe_before", {31'b0, branchPredictedE}, 32'h1);
      advance();
      flushE = 0; stallD = 0;
      branchE = 1; branchTakenE = 0;
      eval();
      chk("t5_bpe_after", {31'b0, branchPredictedE}, 32'h0);
      chk("t5_mis", {31'b0, mispredictE}, 32'h0);
      advance();
      branchE = 0;
      eval(); advance();

      // mid-operation reset discards in-flight predictions
      reset = 1;
      eval(); advance();
      quiet();
      eval();
      chk("rst_bpe", {31'b0, branchPredictedE}, 32'h0);
      chk("rst_pt", {31'b0, predictTakenF}, 32'h0);
      advance();

`ifdef BRANCH_PREDICTOR_GSHARE_EN
      // Test 6: four taken resolves fill the history with ones
      reset = 1; eval(); advance();
      quiet();
      pcF = 32'h08; btbHit = 1; btbBTA = 32'h11;
      eval(); advance();
      eval(); advance();
      branchE = 1; branchTakenE = 1; aluBranchAddress = 32'h11;
      repeat (4) begin eval(); advance(); end
      branchE = 0;
      eval();
      chk("t6_ghr", {28'b0, dut.ghr}, 32'hF);
      chk("t6_idx", {28'b0, dut.idx_f}, 32'hD);
      advance();
`endif

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         reset  = ($urandom_range(0, 59) == 0);
         pcF    = ($urandom_range(0, 15) << 2) | (($urandom_range(0, 3)) << 8);
         btbHit = ($urandom_range(0, 3) != 0);
         btbBTA = {$urandom_range(0, 7), 2'b00};
         stallF = ($urandom_range(0, 5) == 0);
         stallD = ($urandom_range(0, 5) == 0);
         flushD = ($urandom_range(0, 7) == 0);
         flushE = ($urandom_range(0, 7) == 0);
         branchE      = $urandom_range(0, 1);
         branchTakenE = $urandom_range(0, 1);
         aluBranchAddress = $urandom_range(0, 1) ? m_de.target
                                                 : {$urandom_range(0, 7), 2'b00};
         pcE = $urandom;
         eval();
         advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_direction_predictor.md
BRANCH_DIRECTION_PREDICTOR -- requirements
Module: branch_direction_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 4, giving the pattern-history-table index width (2^IDX_W entries).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pcF  input  32  fetch-stage PC.
REQ-005 SHALL have port btbHit  input  1  BTB hit for pcF.
REQ-006 SHALL have port btbBTA  input  32  BTB target for pcF.
REQ-007 SHALL have ports stallF, stallD  input  1 each  hold the F->D and D->E prediction registers.
REQ-008 SHALL have ports flushD, flushE  input  1 each  invalidate the D or E prediction register.
REQ-009 SHALL have port branchE  input  1  E-stage instruction is a conditional branch.
REQ-010 SHALL have port branchTakenE  input  1  resolved branch outcome in E.
REQ-011 SHALL have port aluBranchAddress  input  32  resolved branch target in E.
REQ-012 SHALL have port pcE  input  32  PC of the E-stage instruction.
REQ-013 SHALL have port pcNextF  output  32  predicted next fetch PC.
REQ-014 SHALL have port predictTakenF  output  1  taken prediction for pcF.
REQ-015 SHALL have port branchPredictedE  output  1  prediction carried to E (valid-gated).
REQ-016 SHALL have port mispredictE  output  1  E-stage misprediction; pipeline must flush D and E.
REQ-017 SHALL have port pcRedirectE  output  32  correct fetch PC when mispredictE=1.

Function
REQ-018 Table: 2^IDX_W two-bit saturating counters; 0,1 = not-taken; 2,3 = taken.
REQ-019 Fetch index idxF = pcF[IDX_W+1:2]; predictTakenF = btbHit AND counter[idxF][1], combinational.
REQ-020 pcNextF = btbBTA when predictTakenF=1, else pcF+4 (modulo 2^32).
REQ-021 F->D register holds {valid, predTaken, predTarget, idx}; loads every cycle unless stallF; valid loads 1.
REQ-022 D->E register is loaded from the F->D register unless stallD.
REQ-023 flushD clears F->D valid and predTaken; flushE clears D->E valid and predTaken; flush overrides stall in the same cycle.
REQ-024 branchPredictedE = D->E valid AND predTaken.
REQ-025 Resolve condition: branchE AND D->E valid.
REQ-026 mispredictE = resolve AND ((predTaken != branchTakenE) OR (predTaken AND branchTakenE AND predTarget != aluBranchAddress)); combinational, same cycle.
REQ-027 pcRedirectE = aluBranchAddress when branchTakenE=1, else pcE+4; value is don't-care when mispredictE=0.
REQ-028 On resolve, counter[idxE] increments (saturates at 3) if branchTakenE, else decrements (saturates at 0); written at the next clock edge.
REQ-029 Same-cycle read and update of one index: fetch sees the old counter value; no bypass.
REQ-030 No counter update when resolve=0, including when flushE or stallD is asserted on an invalid entry.
REQ-031 Update uses the index captured at fetch, not pcE.

Reset
REQ-032 On reset: all counters = 1 (weakly not-taken); both pipeline registers valid=0, predTaken=0, predTarget=0, idx=0.
REQ-033 Outputs after reset: branchPredictedE=0, mispredictE=0, predictTakenF=0.
REQ-034 Reset has priority over stall, flush and update in the same cycle; reset asserted mid-operation discards pending predictions.

Configuration
REQ-035 Macro BRANCH_PREDICTOR_GSHARE_EN: when defined, a global-history register of IDX_W bits (reset 0) forms idxF = pcF[IDX_W+1:2] XOR GHR.
REQ-036 With BRANCH_PREDICTOR_GSHARE_EN, on resolve the GHR shifts left and inserts branchTakenE at bit 0.
REQ-037 Without BRANCH_PREDICTOR_GSHARE_EN, there is no GHR and idxF = pcF[IDX_W+1:2].

Verification
REQ-038 Test 1: after reset, pcF=0x08, btbHit=1, btbBTA=0x11 -> predictTakenF=0, pcNextF=0x0C.
REQ-039 Test 2: resolve the branch at pc 0x08 taken twice (aluBranchAddress=0x11) -> counter goes 1->2->3; next fetch of 0x08 with btbHit=1 -> pcNextF=0x11.
REQ-040 Test 3: predicted-taken entry resolves not-taken with pcE=0x08 -> mispredictE=1, pcRedirectE=0x0C; counter 3->2.
REQ-041 Test 4: predicted taken to 0x11, resolved taken to 0x20 -> mispredictE=1, pcRedirectE=0x20.
REQ-042 Test 5: flushE together with stallD on a valid taken prediction -> branchPredictedE=0 next cycle, no counter change.
REQ-043 Test 6 (GSHARE): four taken resolves -> GHR=0xF; idxF for pcF=0x08 equals 0x2 XOR 0xF = 0xD.
